// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA core arbiter: FSM state encoding and
// default sizing for operand width and the per-job timeout.
package rsa_pkg;

    localparam int RSA_DATA_W         = 32;
    localparam int RSA_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ACK   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } rsa_state_t;

endpackage

// File: rtl/rsa_rr_arb.sv
// Two-way round-robin grant selection. When both requesters ask at once the
// one that was not served last wins; a lone requester always wins. The
// last-served record starts at 1 so requester 0 goes first after reset.
module rsa_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last;

    // Pick the winner from the current requests and the last-served record.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Remember who was granted so the other side wins the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else if (take && gnt_valid) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/rsa_arbiter.sv
// Shares one basicrsa core between two requesters. A job is granted, its
// operands are latched and held on core_*, the core is started with a single
// ds pulse, and the result is presented to the owner until it is accepted.
// A job that occupies the core too long resets the core and returns an error.
module rsa_arbiter
    import rsa_pkg::*;
#(
    parameter int DATA_W         = RSA_DATA_W,
    parameter int TIMEOUT_CYCLES = RSA_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_indata,
    input  logic [2*DATA_W-1:0] req_exp,
    input  logic [2*DATA_W-1:0] req_mod,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_error,
    output logic [DATA_W-1:0]   core_indata,
    output logic [DATA_W-1:0]   core_exp,
    output logic [DATA_W-1:0]   core_mod,
    output logic                core_ds,
    output logic                core_reset,
    input  logic [DATA_W-1:0]   core_cypher,
    input  logic                core_ready,
    output logic                busy,
    output logic                owner
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rsa_state_t       state;
    rsa_state_t       state_nx;
    logic [CNT_W-1:0] tmo_cnt;
    logic             abort_cnt;
    logic             rst_hold;
    logic             grant;
    logic             timeout;
    logic             gnt_valid;
    logic             gnt_idx;

    rsa_rr_arb u_rr_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_valid),
        .take      (grant),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state and strobe outputs; grants wait out the core's reset cycle.
    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        core_ds    = 1'b0;
        core_reset = rst_hold;
        busy       = (state != ST_IDLE);
        timeout    = (tmo_cnt >= TMO_LAST);
        case (state)
            ST_IDLE: begin
                if (gnt_valid && !rst_hold) begin
                    grant     = 1'b1;
                    req_ready = gnt_idx ? 2'b10 : 2'b01;
                    state_nx  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_ds  = 1'b1;
                state_nx = ST_ACK;
            end
            ST_ACK: begin
                if (timeout) begin
                    state_nx = ST_ABORT;
                end else if (!core_ready) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timeout) begin
                    state_nx = ST_ABORT;
                end else if (core_ready) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = owner ? 2'b10 : 2'b01;
                if (rsp_ready[owner]) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ABORT: begin
                core_reset = 1'b1;
                if (abort_cnt) begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Keep the core in reset for one extra cycle after reset_n releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
        end
    end

    // Job datapath: latch owner operands on grant, track timeout, build the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_indata <= '0;
            core_exp    <= '0;
            core_mod    <= '0;
            owner       <= 1'b0;
            tmo_cnt     <= '0;
            abort_cnt   <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner       <= gnt_idx;
                        core_indata <= gnt_idx ? req_indata[DATA_W +: DATA_W] : req_indata[0 +: DATA_W];
                        core_exp    <= gnt_idx ? req_exp[DATA_W +: DATA_W]    : req_exp[0 +: DATA_W];
                        core_mod    <= gnt_idx ? req_mod[DATA_W +: DATA_W]    : req_mod[0 +: DATA_W];
                        tmo_cnt     <= '0;
                    end
                end
                ST_ACK: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (state_nx == ST_DONE) begin
                        rsp_data  <= core_cypher;
                        rsp_error <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    abort_cnt <= ~abort_cnt;
                    if (abort_cnt) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready[owner]) begin
                        rsp_error <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_arbiter.sv
// Directed bench for rsa_arbiter with a behavioural basicrsa stand-in that
// computes modular exponentiation after a programmable latency and can be
// stalled to force a timeout.
module tb_rsa_arbiter;

    localparam int DATA_W = 32;
    localparam int TMO    = 64;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic [1:0]          req_valid = 2'b00;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_indata = '0;
    logic [2*DATA_W-1:0] req_exp = '0;
    logic [2*DATA_W-1:0] req_mod = '0;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready = 2'b00;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_error;
    logic [DATA_W-1:0]   core_indata;
    logic [DATA_W-1:0]   core_exp;
    logic [DATA_W-1:0]   core_mod;
    logic                core_ds;
    logic                core_reset;
    logic [DATA_W-1:0]   m_cypher = '0;
    logic                m_ready = 1'b1;
    logic                busy;
    logic                owner;

    logic [DATA_W-1:0]   m_res = '0;
    int                  m_cnt = 0;
    int                  lat = 5;
    bit                  stall = 1'b0;
    int                  ds_count = 0;
    int                  cyc = 0;
    int                  total = 0;
    int                  bad = 0;

    typedef struct {
        int                r;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] res;
    } vec_t;

    vec_t vecs[5];

    rsa_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_indata  (req_indata),
        .req_exp     (req_exp),
        .req_mod     (req_mod),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .core_indata (core_indata),
        .core_exp    (core_exp),
        .core_mod    (core_mod),
        .core_ds     (core_ds),
        .core_reset  (core_reset),
        .core_cypher (m_cypher),
        .core_ready  (m_ready),
        .busy        (busy),
        .owner       (owner)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter and ds pulse counter.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (core_ds) ds_count = ds_count + 1;
    end

    function automatic logic [DATA_W-1:0] modexp(input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] e,
                                                 input logic [DATA_W-1:0] m);
        logic [63:0] r;
        logic [63:0] x;
        r = 64'd1 % {32'd0, m};
        x = {32'd0, b} % {32'd0, m};
        for (int i = 0; i < DATA_W; i++) begin
            if (e[i]) r = (r * x) % {32'd0, m};
            x = (x * x) % {32'd0, m};
        end
        return r[DATA_W-1:0];
    endfunction

    // Behavioural core: ready drops after ds, rises with the result after lat cycles.
    always @(posedge clk) begin
        if (core_reset) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
        end else if (core_ds) begin
            m_ready <= 1'b0;
            m_cnt   <= lat;
            m_res   <= modexp(core_indata, core_exp, core_mod);
        end else if (!m_ready && !stall) begin
            if (m_cnt == 0) begin
                m_ready  <= 1'b1;
                m_cypher <= m_res;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Present one request and wait (bounded) for its accept edge.
    task automatic applyStimulus(input int r, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] m);
        bit ok;
        ok = 1'b0;
        req_indata[r*DATA_W +: DATA_W] = a;
        req_exp[r*DATA_W +: DATA_W]    = e;
        req_mod[r*DATA_W +: DATA_W]    = m;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[r] = 1'b0;
        checkOutput("accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic waitResp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) got = 1'b1;
        end
        checkOutput("rsp_seen", {63'd0, got}, 64'd1);
    endtask

    task automatic ackResp(input int r);
        @(posedge clk);
        #1;
        rsp_ready[r] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[r] = 1'b0;
        checkOutput("rsp_cleared", {62'd0, rsp_valid}, 64'd0);
        checkOutput("idle_after_ack", {63'd0, busy}, 64'd0);
    endtask

    task automatic runJob(input vec_t v);
        int ds0;
        bit got;
        ds0 = ds_count;
        applyStimulus(v.r, v.a, v.e, v.m);
        waitResp(got);
        checkOutput("rsp_valid_bit", {62'd0, rsp_valid}, (v.r == 1) ? 64'd2 : 64'd1);
        checkOutput("rsp_data", {32'd0, rsp_data}, {32'd0, v.res});
        checkOutput("rsp_error", {63'd0, rsp_error}, 64'd0);
        checkOutput("owner", {63'd0, owner}, (v.r == 1) ? 64'd1 : 64'd0);
        checkOutput("ds_pulses", 64'(ds_count - ds0), 64'd1);
        ackResp(v.r);
    endtask

    // Watchdog against a wedged run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        int n;
        int t0;
        int t1;
        int cnt_v;
        int cnt_d;
        int cnt_g;

        vecs[0] = '{r: 0, a: 32'd2, e: 32'd10, m: 32'd1000, res: 32'd24};
        vecs[1] = '{r: 0, a: 32'd7, e: 32'd2,  m: 32'd10,   res: 32'd9};
        vecs[2] = '{r: 1, a: 32'd5, e: 32'd3,  m: 32'd13,   res: 32'd8};
        vecs[3] = '{r: 1, a: 32'd4, e: 32'd13, m: 32'd497,  res: 32'd445};
        vecs[4] = '{r: 0, a: 32'd3, e: 32'd5,  m: 32'd7,    res: 32'd5};

        // Reset values
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {62'd0, req_ready}, 64'd0);
        checkOutput("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        checkOutput("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
        checkOutput("rst_core_ds", {63'd0, core_ds}, 64'd0);
        checkOutput("rst_operands", {32'd0, core_indata | core_exp | core_mod}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_owner", {63'd0, owner}, 64'd0);
        checkOutput("rst_core_reset", {63'd0, core_reset}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("core_reset_after_release", {63'd0, core_reset}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("core_reset_cleared", {63'd0, core_reset}, 64'd0);

        // Both requesting continuously: grants alternate 0,1,0,1
        req_indata = {32'd3, 32'd4};
        req_exp    = {32'd5, 32'd13};
        req_mod    = {32'd7, 32'd497};
        rsp_ready  = 2'b11;
        req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) got = 1'b1;
            end
            checkOutput("rr_grant", {62'd0, req_ready}, (k % 2 == 1) ? 64'd2 : 64'd1);
            @(posedge clk);
            #1;
            if (k == 3) req_valid = 2'b00;
            waitResp(got);
            checkOutput("rr_rsp_valid", {62'd0, rsp_valid}, (k % 2 == 1) ? 64'd2 : 64'd1);
            checkOutput("rr_rsp_data", {32'd0, rsp_data}, (k % 2 == 1) ? 64'd5 : 64'd445);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // Table of single-requester jobs
        foreach (vecs[i]) runJob(vecs[i]);

        // Result held in DONE while owner withholds rsp_ready; no grant to the other side
        applyStimulus(1, 32'd2, 32'd10, 32'd1000);
        waitResp(got);
        req_indata[0 +: DATA_W] = 32'd7;
        req_exp[0 +: DATA_W]    = 32'd2;
        req_mod[0 +: DATA_W]    = 32'd10;
        req_valid[0] = 1'b1;
        cnt_v = 0;
        cnt_d = 0;
        cnt_g = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            rsp_ready[0] = ~rsp_ready[0];
            @(negedge clk);
            if (rsp_valid != 2'b10) cnt_v++;
            if (rsp_data != 32'd24) cnt_d++;
            if (req_ready != 2'b00) cnt_g++;
        end
        checkOutput("hold_valid_glitches", 64'(cnt_v), 64'd0);
        checkOutput("hold_data_glitches", 64'(cnt_d), 64'd0);
        checkOutput("hold_unexpected_grants", 64'(cnt_g), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        ackResp(1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        checkOutput("pending_req0_granted", {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        waitResp(got);
        checkOutput("pending_rsp_valid", {62'd0, rsp_valid}, 64'd1);
        checkOutput("pending_rsp_data", {32'd0, rsp_data}, 64'd9);
        ackResp(0);

        // Timeout: core never comes back
        stall = 1'b1;
        applyStimulus(0, 32'd4, 32'd13, 32'd497);
        @(negedge clk);
        checkOutput("tmo_ds", {63'd0, core_ds}, 64'd1);
        t0 = cyc;
        t1 = t0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (core_reset) begin
                got = 1'b1;
                t1 = cyc;
            end
        end
        checkOutput("tmo_abort_latency", 64'(t1 - t0), 64'(TMO + 1));
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!core_reset) break;
            n++;
        end
        checkOutput("tmo_core_reset_cycles", 64'(n), 64'd2);
        checkOutput("tmo_rsp_valid", {62'd0, rsp_valid}, 64'd1);
        checkOutput("tmo_rsp_error", {63'd0, rsp_error}, 64'd1);
        checkOutput("tmo_rsp_data", {32'd0, rsp_data}, 64'd0);
        stall = 1'b0;
        ackResp(0);
        checkOutput("tmo_error_cleared", {63'd0, rsp_error}, 64'd0);

        // Reset while the core is computing drops the job
        lat = 20;
        applyStimulus(1, 32'd5, 32'd3, 32'd13);
        repeat (4) @(negedge clk);
        checkOutput("mid_in_wait", {62'd0, busy, m_ready}, 64'd2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_busy", {63'd0, busy}, 64'd0);
        checkOutput("mid_owner", {63'd0, owner}, 64'd0);
        checkOutput("mid_operands", {32'd0, core_indata | core_exp | core_mod}, 64'd0);
        checkOutput("mid_strobes", {59'd0, rsp_valid, req_ready, core_ds}, 64'd0);
        checkOutput("mid_core_reset", {63'd0, core_reset}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        lat = 5;
        cnt_v = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) cnt_v++;
        end
        checkOutput("dropped_job_silent", 64'(cnt_v), 64'd0);
        @(posedge clk);
        #1;
        runJob(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_arbiter.md
RSA_ARBITER -- requirements
Module: rsa_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (must match basicrsa).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles a job may occupy the core.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  2  per-requester job request (bit i = requester i).
REQ-006 SHALL have port req_ready  output  2  per-requester job accept strobe.
REQ-007 SHALL have port req_indata  input  2*DATA_W  per-requester message; slice i = [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_exp  input  2*DATA_W  per-requester exponent, same slicing.
REQ-009 SHALL have port req_mod  input  2*DATA_W  per-requester modulus, same slicing.
REQ-010 SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-012 SHALL have port rsp_data  output  DATA_W  result, shared by both requesters, valid only with rsp_valid.
REQ-013 SHALL have port rsp_error  output  1  qualifies rsp_valid: job timed out, rsp_data = 0.
REQ-014 SHALL have port core_indata / core_exp / core_mod  output  DATA_W each  operands to basicrsa.
REQ-015 SHALL have port core_ds  output  1  basicrsa start strobe.
REQ-016 SHALL have port core_reset  output  1  basicrsa active-high reset.
REQ-017 SHALL have port core_cypher  input  DATA_W  basicrsa result.
REQ-018 SHALL have port core_ready  input  1  basicrsa ready (low while computing, high when done/idle).
REQ-019 SHALL have port busy  output  1  high in any state but IDLE.
REQ-020 SHALL have port owner  output  1  index of requester currently granted.

Function
REQ-021 SHALL implement FSM IDLE -> LOAD -> ACK -> WAIT -> DONE -> IDLE, plus ABORT.
REQ-022 IDLE: if any req_valid, grant by round-robin (priority to requester != last served; after reset requester 0 first); assert req_ready[owner] for exactly that cycle, register the owner's operands into core_* registers, go LOAD.
REQ-023 LOAD: core_ds = 1 for exactly one cycle; go ACK.
REQ-024 ACK: wait for core_ready = 0, then go WAIT.
REQ-025 WAIT: on core_ready = 1, capture core_cypher into rsp_data, go DONE.
REQ-026 DONE: hold rsp_valid[owner] = 1 with rsp_data stable until rsp_ready[owner] = 1; then go IDLE same cycle.
REQ-027 Timeout counter SHALL clear on LOAD entry, count in ACK/WAIT; reaching TIMEOUT_CYCLES-1 goes ABORT.
REQ-028 ABORT: core_reset = 1 for 2 cycles, then DONE with rsp_error = 1 and rsp_data = 0.
REQ-029 core_* operand outputs SHALL remain stable from LOAD through DONE.
REQ-030 req_valid changes while not IDLE SHALL be ignored; no request is lost or double-accepted.
REQ-031 Simultaneous requests SHALL grant the non-last-served requester; single request SHALL be granted regardless of history.
REQ-032 rsp_valid SHALL be one-hot or zero; rsp_valid[~owner] always 0.
REQ-033 Deassertion of rsp_ready[~owner] SHALL have no effect.

Reset
REQ-034 On reset_n = 0: state IDLE, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_error = 0, core_ds = 0, core_* operands = 0, busy = 0, owner = 0, last-served = 1, counter = 0.
REQ-035 core_reset SHALL be 1 while reset_n = 0 and for the first cycle after release.
REQ-036 Reset mid-job SHALL drop the job without response.

Structure
REQ-037 Shared package rsa_pkg SHALL hold FSM state enum, DATA_W default, TIMEOUT_CYCLES default.
REQ-038 Round-robin grant logic SHALL be sub-module rsa_rr_arb (2-way, last-served register inside).

Verification
REQ-039 Req0 indata=4, exp=13, mod=497 with model core -> one ds pulse, rsp_valid[0], rsp_data=445.
REQ-040 Both req_valid=1 from reset -> req0 served first, then req1; repeat -> alternation 0,1,0,1.
REQ-041 Core ready held low -> ABORT at TIMEOUT_CYCLES, core_reset 2 cycles, rsp_error=1, rsp_data=0.
REQ-042 rsp_ready held low 50 cycles in DONE -> rsp_valid/rsp_data stable, no new grant.
REQ-043 reset_n asserted in WAIT -> all outputs at reset values next edge; new job completes normally.
